// File: rtl/rf_pkg.sv
// Shared register-file widths and the round-robin pick helper used by the writeback arbiter.
package rf_pkg;
   localparam int unsigned RF_ADDR_W = 5;
   localparam int unsigned RF_DATA_W = 32;
   localparam logic [RF_ADDR_W-1:0] RF_ZERO_REG = 5'd0;
   localparam int unsigned RR_MAX_REQ = 8;
   localparam int unsigned RR_PTR_W = 3;

   // One-hot grant of the first valid bit at or after ptr, wrapping at numReq (ptr < numReq).
   function automatic logic [RR_MAX_REQ-1:0] rr_pick(
      input logic [RR_MAX_REQ-1:0] valid,
      input logic [RR_PTR_W-1:0]   ptr,
      input int unsigned           numReq
   );
      logic [RR_MAX_REQ-1:0] grant;
      logic                  found;
      int unsigned           idx;
      grant = '0;
      found = 1'b0;
      for (int unsigned k = 0; k < RR_MAX_REQ; k++) begin
         idx = 32'(ptr) + k;
         if (idx >= numReq) idx = idx - numReq;
         if (!found && (k < numReq) && valid[3'(idx)]) begin
            grant[3'(idx)] = 1'b1;
            found = 1'b1;
         end
      end
      return grant;
   endfunction
endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant from valid, pointer advances past each winner.
module rr_arbiter
   import rf_pkg::*;
#(
   parameter  int unsigned NUM_REQ = 2,
   localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic [NUM_REQ-1:0] valid,
   input  logic               enable,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grantIdx
);

   logic [IDX_W-1:0]      rrPtr;
   logic [RR_MAX_REQ-1:0] validWide;
   logic [RR_MAX_REQ-1:0] pickWide;

   always_comb begin
      validWide = '0;
      validWide[NUM_REQ-1:0] = valid;
      pickWide = rr_pick(validWide, RR_PTR_W'(rrPtr), NUM_REQ);
      grant = enable ? pickWide[NUM_REQ-1:0] : '0;
      grantIdx = '0;
      for (int unsigned i = 0; i < RR_MAX_REQ; i++) begin
         if (pickWide[i]) grantIdx = IDX_W'(i);
      end
   end

   // Pointer only moves on an actual grant, so hold or idle cycles keep the priority order.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rrPtr <= '0;
      end else if (|grant) begin
         rrPtr <= (32'(grantIdx) == NUM_REQ - 1) ? '0 : grantIdx + IDX_W'(1);
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port among NUM_REQ writeback sources through a one-entry
// commit stage; the stage is also exported as a bypass for same-cycle readers.
module regfile_wb_arbiter
   import rf_pkg::*;
#(
   parameter  int unsigned NUM_REQ = 2,
   parameter  int unsigned ADDR_W  = RF_ADDR_W,
   parameter  int unsigned DATA_W  = RF_DATA_W,
   localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   input  logic                      hold,
   output logic                      rf_we,
   output logic [ADDR_W-1:0]         rf_waddr,
   output logic [DATA_W-1:0]         rf_wdata,
   output logic                      byp_valid,
   output logic [ADDR_W-1:0]         byp_addr,
   output logic [DATA_W-1:0]         byp_data,
   output logic [IDX_W-1:0]          grant_id
);

   logic [NUM_REQ-1:0] grant;
   logic [IDX_W-1:0]   grantIdx;
   logic [ADDR_W-1:0]  selAddr;
   logic [DATA_W-1:0]  selData;
   logic               handshake;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) uArb (
      .clock    (clock),
      .reset_n  (reset_n),
      .valid    (req_valid),
      .enable   (~hold),
      .grant    (grant),
      .grantIdx (grantIdx)
   );

   assign req_ready = reset_n ? grant : '0;
   assign handshake = |(req_valid & req_ready);

   // One-hot mux of the winning requester's payload.
   always_comb begin
      selAddr = '0;
      selData = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            selAddr = selAddr | req_addr[i*ADDR_W +: ADDR_W];
            selData = selData | req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // Commit stage; writes to the zero register are accepted but never enabled.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
         grant_id <= '0;
      end else if (handshake) begin
         rf_we    <= (selAddr != ADDR_W'(RF_ZERO_REG));
         rf_waddr <= selAddr;
         rf_wdata <= selData;
         grant_id <= grantIdx;
      end else begin
         rf_we    <= 1'b0;
      end
   end

   assign byp_valid = rf_we;
   assign byp_addr  = rf_waddr;
   assign byp_data  = rf_wdata;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: directed scenarios plus randomized traffic
// against a queue-based reference model and a shadow register file.
module tb_regfile_wb_arbiter;
   localparam int unsigned N  = 3;
   localparam int unsigned AW = 5;
   localparam int unsigned DW = 32;
   localparam int unsigned IW = $clog2(N);

   typedef struct {
      int            cyc;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      int            id;
   } commit_t;

   logic            clock = 1'b0;
   logic            reset_n = 1'b0;
   logic            hold = 1'b0;
   logic [N-1:0]    req_valid = '0;
   logic [N-1:0]    req_ready;
   logic [N*AW-1:0] req_addr = '0;
   logic [N*DW-1:0] req_data = '0;
   logic            rf_we, byp_valid;
   logic [AW-1:0]   rf_waddr, byp_addr;
   logic [DW-1:0]   rf_wdata, byp_data;
   logic [IW-1:0]   grant_id;

   regfile_wb_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_data(req_data), .hold(hold), .rf_we(rf_we),
      .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .byp_valid(byp_valid),
      .byp_addr(byp_addr), .byp_data(byp_data), .grant_id(grant_id)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int            checks = 0;
   int            errors = 0;
   commit_t       expQ[$];
   int            mPtr = 0;
   logic [DW-1:0] modelRegs [32] = '{default: '0};
   logic [DW-1:0] rfMem [32] = '{default: '0};
   logic [AW-1:0] aArr [N];
   logic [DW-1:0] dArr [N];
   logic [N-1:0]  lastRdy;

   // Shadow register file fed by the write port.
   always @(posedge clock) if (reset_n && rf_we) rfMem[rf_waddr] <= rf_wdata;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One cycle of stimulus: drive, compare ready against the model, record the expected commit.
   task automatic step(input logic [N-1:0] v, input logic h);
      logic [N-1:0] expRdy;
      int win;
      @(posedge clock); #2;
      for (int i = 0; i < N; i++) begin
         req_addr[i*AW +: AW] = aArr[i];
         req_data[i*DW +: DW] = dArr[i];
      end
      req_valid = v;
      hold = h;
      #1;
      expRdy = '0;
      win = -1;
      if (!h) begin
         for (int k = 0; k < N; k++) begin
            if (win < 0 && v[(mPtr + k) % N]) win = (mPtr + k) % N;
         end
      end
      if (win >= 0) expRdy[win] = 1'b1;
      check("req_ready", 64'(req_ready), 64'(expRdy));
      lastRdy = expRdy;
      if (win >= 0) begin
         if (aArr[win] != '0) expQ.push_back('{cyc + 1, aArr[win], dArr[win], win});
         mPtr = (win + 1) % N;
      end
   endtask

   task automatic doReset();
      @(posedge clock); #2;
      reset_n = 1'b0;
      req_valid = '1;
      hold = 1'b0;
      #1;
      check("reset_rf_we", 64'(rf_we), 64'(0));
      check("reset_ready", 64'(req_ready), 64'(0));
      check("reset_grant_id", 64'(grant_id), 64'(0));
      check("reset_waddr", 64'(rf_waddr), 64'(0));
      check("reset_wdata", 64'(rf_wdata), 64'(0));
      expQ.delete();
      mPtr = 0;
      @(posedge clock); #2;
      req_valid = '0;
      @(posedge clock); #2;
      reset_n = 1'b1;
   endtask

   // Monitor: every presented commit must match the head of the scoreboard, on the right cycle.
   always @(negedge clock) begin
      commit_t e;
      if (reset_n) begin
         check("bypass", 64'({byp_valid, byp_addr, byp_data}), 64'({rf_we, rf_waddr, rf_wdata}));
         if (rf_we) begin
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_commit: got addr %0d data %0h, expected no write", rf_waddr, rf_wdata);
            end else begin
               e = expQ.pop_front();
               check("commit_cycle", 64'(cyc), 64'(e.cyc));
               check("commit_addr", 64'(rf_waddr), 64'(e.addr));
               check("commit_data", 64'(rf_wdata), 64'(e.data));
               check("commit_grant_id", 64'(grant_id), 64'(e.id));
               modelRegs[e.addr] = e.data;
            end
         end
      end
   end

   initial begin
      logic [N-1:0] pend;
      for (int i = 0; i < N; i++) begin
         aArr[i] = '0;
         dArr[i] = '0;
      end
      doReset();

      // Single write
      aArr[0] = 5'd5; dArr[0] = 32'hDEAD_BEEF;
      step(3'b001, 1'b0);
      step(3'b000, 1'b0);
      step(3'b000, 1'b0);
      check("reg5", 64'(rfMem[5]), 64'(32'hDEAD_BEEF));

      // Round-robin with two continuous requesters
      aArr[0] = 5'd1; dArr[0] = 32'd1;
      aArr[1] = 5'd2; dArr[1] = 32'd2;
      repeat (6) step(3'b011, 1'b0);

      // Reset with a staged write to register 3
      aArr[1] = 5'd3; dArr[1] = 32'h3333_3333;
      step(3'b010, 1'b0);
      doReset();
      step(3'b000, 1'b0);
      step(3'b000, 1'b0);
      check("reg3_after_reset", 64'(rfMem[3]), 64'(0));

      // Same address from two requesters
      aArr[0] = 5'd7; dArr[0] = 32'h11;
      aArr[1] = 5'd7; dArr[1] = 32'h22;
      step(3'b011, 1'b0);
      step(3'b010, 1'b0);
      step(3'b000, 1'b0);
      step(3'b000, 1'b0);
      check("reg7_final", 64'(rfMem[7]), 64'(32'h22));

      // Write to the zero register
      aArr[1] = 5'd0; dArr[1] = 32'hFFFF_FFFF;
      aArr[0] = 5'd8; dArr[0] = 32'h80;
      aArr[2] = 5'd9; dArr[2] = 32'h99;
      step(3'b010, 1'b0);
      step(3'b111, 1'b0);
      step(3'b000, 1'b0);
      step(3'b000, 1'b0);
      check("reg0_zero", 64'(rfMem[0]), 64'(0));

      // Hold with a staged write in flight
      aArr[0] = 5'd4; dArr[0] = 32'h44;
      step(3'b001, 1'b0);
      aArr[0] = 5'd6; dArr[0] = 32'h66;
      repeat (3) step(3'b001, 1'b1);
      step(3'b001, 1'b0);
      step(3'b000, 1'b0);
      step(3'b000, 1'b0);
      check("reg4_hold", 64'(rfMem[4]), 64'(32'h44));
      check("reg6_hold", 64'(rfMem[6]), 64'(32'h66));

      // Randomized traffic
      pend = '0;
      repeat (400) begin
         for (int i = 0; i < N; i++) begin
            if (pend[i]) begin
               if ($urandom_range(9) == 0) pend[i] = 1'b0;
            end else if ($urandom_range(2) == 0) begin
               pend[i] = 1'b1;
               aArr[i] = AW'($urandom_range(7));
               dArr[i] = $urandom;
            end
         end
         step(pend, ($urandom_range(4) == 0));
         pend = pend & ~lastRdy;
      end

      repeat (3) step(3'b000, 1'b0);
      check("queue_drained", 64'(expQ.size()), 64'(0));
      for (int r = 0; r < 32; r++) begin
         check($sformatf("regfile[%0d]", r), 64'(rfMem[r]), 64'(modelRegs[r]));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
